// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmit-datapath signals shared by the UART transmit arbiter.
// slave is the arbiter side; master is the requester/datapath side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0]   req_valid;
    logic [9*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_load;
    logic [8:0]         tx_data;
    logic               tx_count;
    logic               busy;
    logic [2:0]         grant_id;
    logic               timeout_err;
    logic [CNT_W-1:0]   frame_cnt;

    modport master (
        output req_valid, req_data, tx_count,
        input  req_ready, tx_load, tx_data, busy, grant_id, timeout_err, frame_cnt
    );

    modport slave (
        input  req_valid, req_data, tx_count,
        output req_ready, tx_load, tx_data, busy, grant_id, timeout_err, frame_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmit datapath among N_REQ requesters,
// with inter-frame gap and a BUSY watchdog. Interface N_REQ/CNT_W must match.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for any req_valid; arbitrates on each edge
// LOAD    | one cycle: tx_load and req_ready to the winner
// BUSY    | waiting for a tx_count rising edge or the watchdog
// GAP     | GAP_CYCLES idle clocks before the next arbitration
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;
    localparam logic [1:0] ST_POST = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]       state;
    logic [2:0]       last_grant;
    logic [2:0]       grant_id;
    logic [8:0]       tx_data;
    logic [CNT_W-1:0] frame_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tx_count_q;

    logic             done_rise;
    logic             tmo_hit;
    logic             hi_found;
    logic             lo_found;
    logic [2:0]       hi_id;
    logic [2:0]       lo_id;
    logic [8:0]       hi_data;
    logic [8:0]       lo_data;
    logic [2:0]       win_id;
    logic [8:0]       win_data;
    logic [N_REQ-1:0] ready_vec;

    assign done_rise = bus.tx_count & ~tx_count_q;
    assign tmo_hit   = (tmo_cnt == '0);

    // Descending scan: the last hit is the lowest index. "hi" is restricted to
    // indices above last_grant; if none, wrap to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_data  = '0;
        lo_data  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = 3'(i);
                lo_data  = bus.req_data[9*i +: 9];
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_id    = 3'(i);
                    hi_data  = bus.req_data[9*i +: 9];
                end
            end
        end
        win_id   = hi_found ? hi_id : lo_id;
        win_data = hi_found ? hi_data : lo_data;
    end

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready_vec[i] = (state == ST_LOAD) && (grant_id == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 3'(N_REQ - 1);
            grant_id   <= '0;
            tx_data    <= '0;
            frame_cnt  <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            tx_count_q <= 1'b0;
        end else begin
            tx_count_q <= bus.tx_count;
            case (state)
                ST_IDLE: begin
                    if (lo_found) begin
                        tx_data    <= win_data;
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tmo_cnt <= TMO_LOAD;
                    state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    // completion takes precedence over a coincident watchdog expiry
                    if (done_rise) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        gap_cnt   <= GAP_LOAD;
                        state     <= ST_POST;
                    end else if (tmo_hit) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_POST;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready_vec;
    assign bus.tx_load     = (state == ST_LOAD);
    assign bus.tx_data     = tx_data;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.grant_id    = grant_id;
    assign bus.timeout_err = (state == ST_BUSY) && tmo_hit && !done_rise;
    assign bus.frame_cnt   = frame_cnt;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmit datapath among N requesters. It accepts 9-bit words over a valid/ready handshake and drives a one-cycle load pulse plus the held word into the transmitter. It then waits for the transmitter's frame-complete indication and enforces a programmable inter-frame gap. A watchdog timeout recovers the arbiter if the transmitter never signals completion.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle clocks inserted after each frame (0 = no gap)
TIMEOUT_CYCLES, 200000, max clocks in BUSY before abort (must be >0)
CNT_W, 16, width of frame counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester word valid; held until matching req_ready
req_data  in  9*N_REQ  per-requester word; slice i = bits [9i+8:9i]
req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
tx_load  out  1  one-cycle load strobe to the transmit datapath
tx_data  out  9  word presented to the datapath; stable from LOAD to end of BUSY
tx_count  in  1  frame-complete indication from the datapath; only its rising edge is used
busy  out  1  high in LOAD, BUSY and GAP
grant_id  out  3  index of the current or last granted requester
timeout_err  out  1  one-cycle pulse when the BUSY watchdog expires
frame_cnt  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; outputs req_ready=0, tx_load=0, tx_data=0, busy=0, grant_id=0, timeout_err=0, frame_cnt=0.
  - Internal last_grant=N_REQ-1, so requester 0 has priority first.
  - The tx_count edge-detect register clears to 0.
- Edge detect: done_rise = tx_count & ~tx_count_q, where tx_count_q is registered every cycle.
- IDLE:
  - If any req_valid bit is set, the winner is the first set bit searching upward from last_grant+1, wrapping modulo N_REQ.
  - On that edge: latch the winner's slice into tx_data, set grant_id=last_grant=winner, go to LOAD.
  - If no req_valid bit is set, stay in IDLE.
- LOAD (exactly 1 cycle):
  - tx_load=1 and req_ready[grant_id]=1; all other req_ready bits are 0.
  - Clear the timeout counter; go to BUSY.
- BUSY:
  - Increment the timeout counter each cycle.
  - On done_rise: frame_cnt+1 (wraps); go to GAP, or to IDLE if GAP_CYCLES=0.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: timeout_err=1 for one cycle, frame_cnt unchanged, go to GAP (or IDLE).
  - If done_rise and timeout hit in the same cycle, completion wins and there is no error.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - Requests are ignored during GAP.
- done_rise outside BUSY is ignored. A level already high on entry to BUSY does not count; only a new rising edge completes the frame.
- Handshake timing:
  - A requester sees req_ready exactly 2 cycles after arbitration can first consider it (IDLE sample edge, then the LOAD cycle).
  - A requester may drop req_valid, or present its next word, in the cycle after req_ready.
  - req_data changes after the IDLE sample edge do not affect tx_data.
- Fairness: with all requesters valid continuously, grants cycle 0,1,...,N_REQ-1,0,...
- Minimum frame-to-frame spacing: LOAD to the next tx_load is at least 1 (LOAD) + BUSY duration + GAP_CYCLES + 1 (IDLE) cycles.
- Reset mid-operation: the arbiter returns immediately to IDLE and drops tx_load and req_ready. No partial grant survives, and the priority pointer is restored to requester 0.
- Flag in review: timeout counter width = clog2(TIMEOUT_CYCLES); gap counter width = clog2(GAP_CYCLES+1).

Test Plan:
- Reset then single request: req_valid=0001, data0=9'h155 → next-cycle LOAD with tx_load=1, req_ready=0001, tx_data=9'h155, busy=1; tx_count pulse → frame_cnt=1; after 16 GAP cycles busy=0.
- All four requesters valid continuously with distinct data → grant_id sequence 0,1,2,3,0; each req_ready pulses once per grant; tx_data matches the granted slice.
- Requester 2 only, with last_grant=3 → winner 2 (wrap search from 0); then requesters 1 and 3 valid → 3 wins before 1.
- Hold tx_count low with TIMEOUT_CYCLES=50 → timeout_err pulses exactly 50 cycles after LOAD; frame_cnt unchanged; arbiter returns to IDLE after the gap and serves the next request.
- tx_count already high on entry to BUSY and held high → no completion; drop it and re-raise → completion counted exactly once. Simultaneous done_rise and timeout → no error, frame_cnt+1.
- Assert reset_n=0 during BUSY → all outputs 0 immediately; after release, requester 0 is granted first even if the previous grant was 0; frame_cnt=0; set frame_cnt near 2^CNT_W-1 in a separate run → wraps to 0.
